// File: rtl/elevator_car_controller.sv
// Elevator car controller: serves 2-bit floor requests for floors 0..3,
// times floor-to-floor travel and door dwell, and keeps one pending request.
//
// Request handshake: request_valid is a single-cycle strobe with no ready.
// floor_destiny is sampled only on a rising clk edge where request_valid=1.
// Every strobe is consumed in that same cycle. It is either served
// (from IDLE), held as a door-hold (same floor while the door is open),
// written into the one-deep pending slot, or dropped (same floor while moving).
module elevator_car_controller #(
  parameter int TRAVEL_CYCLES = 8,
  parameter int DOOR_CYCLES   = 16,
  parameter int CNT_W         = 8
) (
  input  logic       clk,
  input  logic       reset,
  input  logic [1:0] floor_destiny,
  input  logic       request_valid,
  output logic [1:0] current_floor,
  output logic       motor_up,
  output logic       motor_down,
  output logic       door_open,
  output logic       arrived,
  output logic       busy,
  output logic       pending_valid,
  output logic [1:0] state_dbg
);

  typedef enum logic [1:0] {
    ST_IDLE      = 2'd0,
    ST_MOVE_UP   = 2'd1,
    ST_MOVE_DOWN = 2'd2,
    ST_DOOR_OPEN = 2'd3
  } state_t;

  localparam logic [CNT_W-1:0] TRAVEL_LAST = CNT_W'(TRAVEL_CYCLES - 1);
  localparam logic [CNT_W-1:0] DOOR_LAST   = CNT_W'(DOOR_CYCLES - 1);

  state_t           state_q, state_d;
  logic [1:0]       floor_q, floor_d;
  logic [1:0]       target_q, target_d;
  logic [CNT_W-1:0] timer_q, timer_d;
  logic             pend_valid_q, pend_valid_d;
  logic [1:0]       pend_floor_q, pend_floor_d;
  logic             arrived_q, arrived_d;

  logic             srv_valid;
  logic [1:0]       srv_floor;
  logic [1:0]       floor_up;
  logic [1:0]       floor_dn;

  // State, position, timer and pending registers; reset parks the car at floor 0
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q      <= ST_IDLE;
      floor_q      <= 2'd0;
      target_q     <= 2'd0;
      timer_q      <= '0;
      pend_valid_q <= 1'b0;
      pend_floor_q <= 2'd0;
      arrived_q    <= 1'b0;
    end else begin
      state_q      <= state_d;
      floor_q      <= floor_d;
      target_q     <= target_d;
      timer_q      <= timer_d;
      pend_valid_q <= pend_valid_d;
      pend_floor_q <= pend_floor_d;
      arrived_q    <= arrived_d;
    end
  end

  // Next-state logic: request selection, travel and door timing, pending capture
  always_comb begin
    state_d      = state_q;
    floor_d      = floor_q;
    target_d     = target_q;
    timer_d      = timer_q;
    pend_valid_d = pend_valid_q;
    pend_floor_d = pend_floor_q;
    arrived_d    = 1'b0;
    srv_valid    = 1'b0;
    srv_floor    = 2'd0;
    floor_up     = floor_q + 2'd1;
    floor_dn     = floor_q - 2'd1;

    // While busy, a request for another floor overwrites the pending slot
    if (state_q != ST_IDLE && request_valid && floor_destiny != floor_q) begin
      pend_valid_d = 1'b1;
      pend_floor_d = floor_destiny;
    end

    case (state_q)
      ST_IDLE: begin
        if (pend_valid_q) begin
          // Pending wins; a simultaneous new request takes its place in the slot
          srv_valid    = 1'b1;
          srv_floor    = pend_floor_q;
          pend_valid_d = request_valid;
          if (request_valid) begin
            pend_floor_d = floor_destiny;
          end
        end else if (request_valid) begin
          srv_valid = 1'b1;
          srv_floor = floor_destiny;
        end
        if (srv_valid) begin
          timer_d = '0;
          if (srv_floor > floor_q) begin
            target_d = srv_floor;
            state_d  = ST_MOVE_UP;
          end else if (srv_floor < floor_q) begin
            target_d = srv_floor;
            state_d  = ST_MOVE_DOWN;
          end else begin
            state_d   = ST_DOOR_OPEN;
            arrived_d = 1'b1;
          end
        end
      end

      ST_MOVE_UP: begin
        if (timer_q == TRAVEL_LAST) begin
          timer_d = '0;
          floor_d = floor_up;
          if (floor_up == target_q) begin
            state_d   = ST_DOOR_OPEN;
            arrived_d = 1'b1;
          end
        end else begin
          timer_d = timer_q + 1'b1;
        end
      end

      ST_MOVE_DOWN: begin
        if (timer_q == TRAVEL_LAST) begin
          timer_d = '0;
          floor_d = floor_dn;
          if (floor_dn == target_q) begin
            state_d   = ST_DOOR_OPEN;
            arrived_d = 1'b1;
          end
        end else begin
          timer_d = timer_q + 1'b1;
        end
      end

      ST_DOOR_OPEN: begin
        // A call for this floor restarts the dwell instead of being queued
        if (request_valid && floor_destiny == floor_q) begin
          timer_d = '0;
        end else if (timer_q == DOOR_LAST) begin
          timer_d = '0;
          state_d = ST_IDLE;
        end else begin
          timer_d = timer_q + 1'b1;
        end
      end

      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  // Outputs decoded from state so reset drops the motor immediately
  always_comb begin
    current_floor = floor_q;
    motor_up      = (state_q == ST_MOVE_UP);
    motor_down    = (state_q == ST_MOVE_DOWN);
    door_open     = (state_q == ST_DOOR_OPEN);
    arrived       = arrived_q;
    busy          = (state_q != ST_IDLE);
    pending_valid = pend_valid_q;
    state_dbg     = state_q;
  end

endmodule

// File: tb/tb_elevator_car_controller.sv
// Directed bench for elevator_car_controller (TRAVEL=8, DOOR=16).
// Edges are numbered E<n> relative to the edge that latches each request.
module tb_elevator_car_controller;

  logic       clk;
  logic       reset;
  logic [1:0] floor_destiny;
  logic       request_valid;
  logic [1:0] current_floor;
  logic       motor_up;
  logic       motor_down;
  logic       door_open;
  logic       arrived;
  logic       busy;
  logic       pending_valid;
  logic [1:0] state_dbg;

  int n_total;
  int n_pass;
  int up_cnt;
  int dn_cnt;
  int door_cnt;
  int arr_cnt;
  int both_cnt;

  elevator_car_controller #(
    .TRAVEL_CYCLES(8),
    .DOOR_CYCLES  (16),
    .CNT_W        (8)
  ) dut (
    .clk          (clk),
    .reset        (reset),
    .floor_destiny(floor_destiny),
    .request_valid(request_valid),
    .current_floor(current_floor),
    .motor_up     (motor_up),
    .motor_down   (motor_down),
    .door_open    (door_open),
    .arrived      (arrived),
    .busy         (busy),
    .pending_valid(pending_valid),
    .state_dbg    (state_dbg)
  );

  // clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_total++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
  endtask

  // One clock edge, then sample 1ns later and accumulate activity counters
  task automatic step(input int n);
    for (int i = 0; i < n; i++) begin
      @(posedge clk);
      #1;
      if (motor_up) up_cnt++;
      if (motor_down) dn_cnt++;
      if (door_open) door_cnt++;
      if (arrived) arr_cnt++;
      if (motor_up && motor_down) both_cnt++;
    end
  endtask

  task automatic clear_counts();
    up_cnt = 0; dn_cnt = 0; door_cnt = 0; arr_cnt = 0; both_cnt = 0;
  endtask

  // Single-cycle request strobe; consumes one edge (E1 of the request)
  task automatic req(input logic [1:0] f);
    request_valid = 1'b1;
    floor_destiny = f;
    step(1);
    request_valid = 1'b0;
    floor_destiny = 2'd0;
  endtask

  initial begin
    n_total = 0;
    n_pass  = 0;
    clear_counts();
    reset = 1'b1;
    request_valid = 1'b0;
    floor_destiny = 2'd0;
    step(2);
    check("reset_floor", current_floor, 0);
    check("reset_busy", busy, 0);
    check("reset_motor", {motor_up, motor_down}, 0);
    check("reset_door", {door_open, arrived, pending_valid}, 0);
    reset = 1'b0;
    step(1);

    // Test 1: 0 -> 2
    clear_counts();
    req(2);                                   // E1
    check("t1_up_start", motor_up, 1);
    check("t1_floor_e1", current_floor, 0);
    check("t1_state_e1", state_dbg, 1);
    step(7);                                  // E8
    check("t1_floor_e8", current_floor, 0);
    step(1);                                  // E9
    check("t1_floor_e9", current_floor, 1);
    step(8);                                  // E17
    check("t1_floor_e17", current_floor, 2);
    check("t1_door_e17", {door_open, arrived, motor_up}, 3'b110);
    step(1);                                  // E18
    check("t1_arr_e18", {door_open, arrived}, 2'b10);
    step(15);                                 // E33
    check("t1_idle", {busy, door_open}, 0);
    check("t1_up_cycles", up_cnt, 16);
    check("t1_door_cycles", door_cnt, 16);
    check("t1_arr_pulses", arr_cnt, 1);

    // Test 2: 2 -> 3, then 3 -> 0
    req(3);
    step(24);
    check("t2_at3", {busy, current_floor}, 3'b011);
    clear_counts();
    req(0);                                   // E1
    check("t2_down_start", {motor_up, motor_down}, 2'b01);
    step(8);                                  // E9
    check("t2_floor_e9", current_floor, 2);
    step(8);                                  // E17
    check("t2_floor_e17", current_floor, 1);
    step(8);                                  // E25
    check("t2_floor_e25", current_floor, 0);
    check("t2_door_e25", {door_open, arrived, motor_down}, 3'b110);
    check("t2_dn_cycles", dn_cnt, 24);
    step(16);                                 // E41
    check("t2_idle", busy, 0);
    check("t2_up_cycles", up_cnt, 0);

    // Test 3: same-floor request and door hold
    req(1);
    step(24);
    check("t3_at1", {busy, current_floor}, 3'b001);
    clear_counts();
    req(1);                                   // E1: door timer 0
    check("t3_door_e1", {door_open, arrived, motor_up, motor_down}, 4'b1100);
    step(10);                                 // E11: door timer 10
    req(1);                                   // E12: timer restarts
    check("t3_not_queued", pending_valid, 0);
    step(15);                                 // E27
    check("t3_door_e27", door_open, 1);
    step(1);                                  // E28
    check("t3_closed_e28", {door_open, busy}, 0);
    check("t3_motor_none", up_cnt + dn_cnt, 0);
    check("t3_arr_pulses", arr_cnt, 1);
    check("t3_door_cycles", door_cnt, 27);

    // Test 4: 0 -> 3 with requests 1 then 2 queued, then 3 -> 2
    req(0);
    step(24);
    check("t4_at0", {busy, current_floor}, 0);
    req(3);                                   // E1
    step(1);                                  // E2
    req(1);                                   // E3
    req(2);                                   // E4
    check("t4_pending", pending_valid, 1);
    step(21);                                 // E25
    check("t4_at3", {current_floor, door_open, arrived}, 4'b1111);
    step(16);                                 // E41
    check("t4_idle_pend", {busy, pending_valid}, 2'b01);
    step(1);                                  // E42
    check("t4_down_start", {motor_down, pending_valid}, 2'b10);
    step(7);                                  // E49
    check("t4_floor_e49", current_floor, 3);
    step(1);                                  // E50
    check("t4_at2", {current_floor, door_open, arrived}, 4'b1011);
    step(16);                                 // E66
    check("t4_idle", {busy, current_floor}, 3'b010);

    // Test 5: pending 3 served before a simultaneous request 0
    req(1);                                   // E1
    req(3);                                   // E2
    step(23);                                 // E25
    check("t5_idle_pend", {busy, pending_valid, current_floor}, 4'b0101);
    req(0);                                   // E26
    check("t5_serve3", {motor_up, motor_down, pending_valid}, 3'b101);
    step(16);                                 // E42
    check("t5_at3", {current_floor, door_open}, 3'b111);
    step(16);                                 // E58
    check("t5_idle_pend0", {busy, pending_valid}, 2'b01);
    step(1);                                  // E59
    check("t5_down", {motor_down, pending_valid}, 2'b10);
    step(24);                                 // E83
    check("t5_at0", {current_floor, door_open}, 3'b001);
    step(16);                                 // E99
    check("t5_idle", busy, 0);
    check("t5_never_both", both_cnt, 0);

    // Test 6: asynchronous reset mid-move (floor 1 toward 2, timer 5)
    req(2);                                   // E1
    step(13);                                 // E14
    check("t6_premove", {motor_up, current_floor}, 3'b101);
    reset = 1'b1;
    #1;
    check("t6_async_motor", {motor_up, motor_down, busy}, 0);
    check("t6_async_floor", current_floor, 0);
    step(2);
    reset = 1'b0;
    step(1);
    check("t6_after", {busy, state_dbg, current_floor, pending_valid}, 0);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

  // Watchdog so the run always ends
  initial begin
    #200000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog");
  end

endmodule
